priority_dec_2_4_v: RTL and testbench



---
 rtl/priority_dec_2_4_v.sv | 113 +++++++++++
 tb/tb_priority_dec_2_4_v.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/priority_dec_2_4_v.sv
// rtl/priority_dec_2_4_v.sv - queued 2-to-4 decoder replaying codes as fixed-width one-hot strobes
module priority_dec_2_4_v #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [1:0]               i_code,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [3:0]               o_line,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      line_q, line_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [1:0]      mem_q [DEPTH];
    logic [1:0]      head;
    logic            push, pop;

    assign head    = mem_q[rd_ptr_q];
    // No pass-through when full: ready depends only on the registered level.
    assign o_ready = (level_q != FULL);
    assign push    = i_valid && o_ready;

    assign o_line  = line_q;
    assign o_busy  = (state_q == DRIVE);
    assign o_level = level_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                line_d = 4'b0000;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    line_d  = 4'b0001 << head;
                    cnt_d   = CNT_LOAD;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (level_q != '0) begin
                    // Back-to-back replay keeps strobes contiguous with no idle gap.
                    pop    = 1'b1;
                    line_d = 4'b0001 << head;
                    cnt_d  = CNT_LOAD;
                end else begin
                    line_d  = 4'b0000;
                    state_d = IDLE;
                end
            end
            default: begin
                line_d  = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            line_q   <= 4'b0000;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read below the write pointer.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_code;
        end
    end

endmodule

// File: tb/tb_priority_dec_2_4_v.sv
// tb/tb_priority_dec_2_4_v.sv - scoreboard bench for priority_dec_2_4_v
module tb_priority_dec_2_4_v;

    localparam int DEPTH = 4;
    localparam int HOLD  = 3;

    logic       clk;
    logic       i_rst_n;
    logic [1:0] i_code;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] o_line;
    logic       o_busy;
    logic [$clog2(DEPTH):0] o_level;

    int total = 0;
    int bad   = 0;
    int peak  = 0;
    logic [1:0] sb [$];

    priority_dec_2_4_v #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_code  (i_code),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_line  (o_line),
        .o_busy  (o_busy),
        .o_level (o_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        i_valid = 1'b1;
        i_code  = c;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (o_ready) begin
                sb.push_back(c);
                tick();
                done = 1'b1;
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            check("push_timeout", 0, 1);
            i_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (!o_busy && o_level == 0) done = 1'b1;
            else tick();
        end
        check("drain_timeout", int'(done), 1);
    endtask

    // Monitor: every new strobe pops the scoreboard; every strobe must last HOLD cycles.
    logic [3:0] prev_line;
    int         run_len;
    always @(negedge clk) begin
        if (!i_rst_n) begin
            prev_line = 4'b0000;
            run_len   = 0;
        end else begin
            if (int'(o_level) > peak) peak = int'(o_level);
            check("onehot", int'($onehot0(o_line)), 1);
            if (o_line != 4'b0000) begin
                if (run_len == 0 || o_line != prev_line || run_len == HOLD) begin
                    if (run_len != 0 && o_line != prev_line) check("hold_len", run_len, HOLD);
                    if (sb.size() == 0) begin
                        check("unexpected_line", int'(o_line), 0);
                    end else begin
                        logic [1:0] exp_code;
                        logic [3:0] exp_line;
                        exp_code = sb.pop_front();
                        exp_line = 4'b0001 << exp_code;
                        check("order", int'(o_line), int'(exp_line));
                    end
                    run_len = 1;
                end else begin
                    run_len++;
                end
            end else begin
                if (run_len != 0) check("hold_len", run_len, HOLD);
                run_len = 0;
            end
            prev_line = o_line;
        end
    end

    initial begin
        int st;
        logic [3:0] t3 [9];
        t3 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
               4'b1000, 4'b1000, 4'b1000, 4'b0000};

        // Reset with valid high: nothing may be captured.
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_code  = 2'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_line", int'(o_line), 0);
            check("rst_level", int'(o_level), 0);
            check("rst_ready", int'(o_ready), 1);
            check("rst_busy", int'(o_busy), 0);
        end
        i_valid = 1'b0;
        i_rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_level", int'(o_level), 0);
        check("post_rst_line", int'(o_line), 0);

        // Single code: one cycle latency, HOLD cycles wide.
        push(2'd2, st);
        i_valid = 1'b0;
        check("single_lat_line", int'(o_line), 0);
        check("single_lat_level", int'(o_level), 1);
        tick();
        check("single_line1", int'(o_line), 4);
        check("single_busy1", int'(o_busy), 1);
        check("single_level1", int'(o_level), 0);
        tick();
        tick();
        check("single_line3", int'(o_line), 4);
        tick();
        check("single_line4", int'(o_line), 0);
        check("single_busy4", int'(o_busy), 0);

        // Back-to-back 0,1,3 with no gap, peak occupancy 2.
        peak = 0;
        push(2'd0, st);
        push(2'd1, st);
        push(2'd3, st);
        i_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check("b2b_line", int'(o_line), int'(t3[k]));
            tick();
        end
        check("b2b_peak", peak, 2);
        wait_idle();

        // Back-pressure: FIFO fills, blocked code waits for a pop.
        push(2'd3, st);
        push(2'd2, st);
        push(2'd1, st);
        push(2'd0, st);
        push(2'd3, st);
        push(2'd2, st);
        check("full_level", int'(o_level), 4);
        check("full_ready", int'(o_ready), 0);
        push(2'd1, st);
        i_valid = 1'b0;
        check("full_stalls", st, 2);
        check("full_level_after", int'(o_level), 4);
        wait_idle();

        // Wrap-around with sparse pushes.
        peak = 0;
        for (int k = 0; k < 10; k++) begin
            push(2'(k % 4), st);
            i_valid = 1'b0;
            tick();
            tick();
        end
        wait_idle();
        check("wrap_peak_le2", int'(peak <= 2), 1);

        // Reset during the second cycle of code 1 discards code 2.
        push(2'd1, st);
        push(2'd2, st);
        i_valid = 1'b0;
        check("mid_line_a", int'(o_line), 2);
        tick();
        check("mid_line_b", int'(o_line), 2);
        i_rst_n = 1'b0;
        sb.delete();
        tick();
        check("mid_rst_line", int'(o_line), 0);
        check("mid_rst_level", int'(o_level), 0);
        check("mid_rst_busy", int'(o_busy), 0);
        check("mid_rst_ready", int'(o_ready), 1);
        i_rst_n = 1'b1;
        repeat (8) tick();
        check("mid_after_level", int'(o_level), 0);
        check("mid_after_line", int'(o_line), 0);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
